// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//   Down-counting mm:ss timer. A preset time is loaded and then decremented
//   once per second while running. When the count reaches 00:00 the timer
//   raises a one-cycle done pulse and holds the expired flag until the next
//   load. The mm/ss outputs use the same 6-bit binary format as the
//   elapsed-time stopwatch, so both can feed one display path.
//
// Parameters
//   TICKS_PER_SEC : clk cycles per one-second decrement (>= 2)
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-high reset
//   load    in   capture mm_in/ss_in (ignored while running)
//   mm_in   in   [5:0] preset minutes, saturated to 59
//   ss_in   in   [5:0] preset seconds, saturated to 59
//   start   in   begin/resume counting from a non-zero time
//   pause   in   hold the count, keeping the partial second
//   mm      out  [5:0] current minutes
//   ss      out  [5:0] current seconds
//   running out  high while counting
//   done    out  one-cycle pulse on the edge the count reaches 00:00
//   expired out  high once the count has reached 00:00, until the next load
// -----------------------------------------------------------------------------
module countdown_timer #(
   parameter int TICKS_PER_SEC = 100_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [5:0] mm_in,
   input  logic [5:0] ss_in,
   input  logic       start,
   input  logic       pause,
   output logic [5:0] mm,
   output logic [5:0] ss,
   output logic       running,
   output logic       done,
   output logic       expired
);

   localparam int PW = $clog2(TICKS_PER_SEC);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
   localparam logic [PW-1:0] PRESC_ONE = PW'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Clamp a preset field to the legal 0..59 range.
   function automatic logic [5:0] sat59(input logic [5:0] v);
      if (v > 6'd59) begin
         return 6'd59;
      end else begin
         return v;
      end
   endfunction

   // One-second decrement of {mm,ss} with borrow; 00:00 stays 00:00.
   function automatic logic [11:0] dec_time(input logic [5:0] m, input logic [5:0] s);
      if (s != 6'd0) begin
         return {m, s - 6'd1};
      end else if (m != 6'd0) begin
         return {m - 6'd1, 6'd59};
      end else begin
         return {m, s};
      end
   endfunction

   state_t        state_r, state_s;
   logic [5:0]    mm_r, mm_s;
   logic [5:0]    ss_r, ss_s;
   logic [PW-1:0] presc_r, presc_s;
   logic          done_r, done_s;
   logic          running_r;
   logic          expired_r;
   logic [11:0]   dec_s;
   logic          nonzero_s;

   // Next-state, next-count and done-pulse logic.
   always_comb begin
      state_s   = state_r;
      mm_s      = mm_r;
      ss_s      = ss_r;
      presc_s   = presc_r;
      done_s    = 1'b0;
      dec_s     = dec_time(mm_r, ss_r);
      nonzero_s = ({mm_r, ss_r} != 12'd0);

      case (state_r)
         ST_IDLE, ST_PAUSE: begin
            if (load) begin
               mm_s    = sat59(mm_in);
               ss_s    = sat59(ss_in);
               presc_s = {PW{1'b0}};
               state_s = ST_IDLE;
            end else if (start && nonzero_s) begin
               // start beats a simultaneous pause, so PAUSE resumes here
               state_s = ST_RUN;
            end else begin
               state_s = state_r;
            end
         end
         ST_RUN: begin
            // load and a lone start are ignored while counting
            if (pause) begin
               state_s = ST_PAUSE;
            end else if (presc_r == PRESC_MAX) begin
               presc_s = {PW{1'b0}};
               mm_s    = dec_s[11:6];
               ss_s    = dec_s[5:0];
               if (dec_s == 12'd0) begin
                  state_s = ST_DONE;
                  done_s  = 1'b1;
               end else begin
                  state_s = ST_RUN;
               end
            end else begin
               presc_s = presc_r + PRESC_ONE;
            end
         end
         ST_DONE: begin
            if (load) begin
               mm_s    = sat59(mm_in);
               ss_s    = sat59(ss_in);
               presc_s = {PW{1'b0}};
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
            mm_s    = 6'd0;
            ss_s    = 6'd0;
            presc_s = {PW{1'b0}};
         end
      endcase
   end

   // State, count and registered status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         mm_r      <= 6'd0;
         ss_r      <= 6'd0;
         presc_r   <= {PW{1'b0}};
         done_r    <= 1'b0;
         running_r <= 1'b0;
         expired_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         mm_r      <= mm_s;
         ss_r      <= ss_s;
         presc_r   <= presc_s;
         done_r    <= done_s;
         running_r <= (state_s == ST_RUN);
         expired_r <= (state_s == ST_DONE);
      end
   end

   assign mm      = mm_r;
   assign ss      = ss_r;
   assign running = running_r;
   assign done    = done_r;
   assign expired = expired_r;

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
//   Directed bench for countdown_timer with TICKS_PER_SEC = 4. A model that
//   tracks the remaining time as a plain count of seconds is compared with
//   the DUT on every falling clock edge; hand-computed literal checks pin
//   both the DUT and the model at key points.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

   localparam int TPS = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       load, start, pause;
   logic [5:0] mm_in, ss_in;
   logic [5:0] mm, ss;
   logic       running, done, expired;

   int checks = 0;
   int errors = 0;

   countdown_timer #(.TICKS_PER_SEC(TPS)) dut (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .mm_in   (mm_in),
      .ss_in   (ss_in),
      .start   (start),
      .pause   (pause),
      .mm      (mm),
      .ss      (ss),
      .running (running),
      .done    (done),
      .expired (expired)
   );

   always #5 clk = ~clk;

   // Model: remaining seconds, cycles into the current second, and mode.
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   int m_rem  = 0;
   int m_frac = 0;
   int m_mode = M_IDLE;
   bit m_done = 1'b0;

   // Advance the model on each clock edge using the sampled inputs.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_rem  = 0;
         m_frac = 0;
         m_mode = M_IDLE;
         m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (load && m_mode != M_RUN) begin
            m_rem  = ((int'(mm_in) > 59) ? 59 : int'(mm_in)) * 60
                   + ((int'(ss_in) > 59) ? 59 : int'(ss_in));
            m_frac = 0;
            m_mode = M_IDLE;
         end else if (m_mode == M_IDLE || m_mode == M_PAUSE) begin
            if (start && m_rem != 0) m_mode = M_RUN;
         end else if (m_mode == M_RUN) begin
            if (pause) begin
               m_mode = M_PAUSE;
            end else begin
               m_frac = m_frac + 1;
               if (m_frac == TPS) begin
                  m_frac = 0;
                  m_rem  = m_rem - 1;
                  if (m_rem == 0) begin
                     m_mode = M_DONE;
                     m_done = 1'b1;
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of DUT outputs against the model.
   always @(negedge clk) begin
      if (!rst) begin
         chk("cyc_mm",      int'(mm),      m_rem / 60);
         chk("cyc_ss",      int'(ss),      m_rem % 60);
         chk("cyc_running", int'(running), (m_mode == M_RUN) ? 1 : 0);
         chk("cyc_expired", int'(expired), (m_mode == M_DONE) ? 1 : 0);
         chk("cyc_done",    int'(done),    int'(m_done));
      end
   end

   // Drive one cycle of inputs from a falling edge, then clear them.
   task automatic cyc(input logic l, input int mi, input int si, input logic st, input logic pa);
      load  = l;
      mm_in = 6'(mi);
      ss_in = 6'(si);
      start = st;
      pause = pa;
      @(negedge clk);
      load  = 1'b0;
      start = 1'b0;
      pause = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst   = 1'b1;
      load  = 1'b0;
      start = 1'b0;
      pause = 1'b0;
      mm_in = 6'd0;
      ss_in = 6'd0;
      #3;
      chk("rst_mm",      int'(mm),      0);
      chk("rst_ss",      int'(ss),      0);
      chk("rst_running", int'(running), 0);
      chk("rst_done",    int'(done),    0);
      chk("rst_expired", int'(expired), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 1: 00:03 counts 3,2,1,0 every 4 clocks
      cyc(1'b1, 0, 3, 1'b0, 1'b0);
      chk("t1_load_ss", int'(ss), 3);
      cyc(1'b0, 0, 0, 1'b1, 1'b0);
      chk("t1_running", int'(running), 1);
      idle(3);
      chk("t1_ss_hold", int'(ss), 3);
      idle(1);
      chk("t1_ss_2", int'(ss), 2);
      idle(8);
      chk("t1_ss_0",      int'(ss),      0);
      chk("t1_done",      int'(done),    1);
      chk("t1_expired",   int'(expired), 1);
      chk("t1_run_off",   int'(running), 0);
      idle(1);
      chk("t1_done_once", int'(done),    0);
      chk("t1_exp_hold",  int'(expired), 1);

      // 2: 01:00 borrows to 00:59, expires after 240 clocks
      cyc(1'b1, 1, 0, 1'b0, 1'b0);
      chk("t2_model_rem", m_rem, 60);
      cyc(1'b0, 0, 0, 1'b1, 1'b0);
      idle(4);
      chk("t2_borrow_mm", int'(mm), 0);
      chk("t2_borrow_ss", int'(ss), 59);
      idle(235);
      chk("t2_pre_done", int'(done), 0);
      idle(1);
      chk("t2_done", int'(done), 1);
      chk("t2_ss",   int'(ss),   0);

      // 3: pause keeps the partial second
      cyc(1'b1, 0, 5, 1'b0, 1'b0);
      cyc(1'b0, 0, 0, 1'b1, 1'b0);
      idle(6);
      chk("t3_model_frac", m_frac, 2);
      cyc(1'b0, 0, 0, 1'b0, 1'b1);
      chk("t3_pause_ss",  int'(ss),      4);
      chk("t3_pause_run", int'(running), 0);
      idle(20);
      chk("t3_held_ss", int'(ss), 4);
      cyc(1'b0, 0, 0, 1'b1, 1'b0);
      idle(1);
      chk("t3_resume_1", int'(ss), 4);
      idle(1);
      chk("t3_resume_2", int'(ss), 3);
      cyc(1'b0, 0, 0, 1'b0, 1'b1);

      // 4: saturation of preset, zero preset never runs
      cyc(1'b1, 63, 60, 1'b0, 1'b0);
      chk("t4_sat_mm", int'(mm), 59);
      chk("t4_sat_ss", int'(ss), 59);
      cyc(1'b1, 0, 0, 1'b0, 1'b0);
      cyc(1'b0, 0, 0, 1'b1, 1'b0);
      chk("t4_zero_run", int'(running), 0);
      idle(5);
      chk("t4_zero_done", int'(done),    0);
      chk("t4_zero_exp",  int'(expired), 0);

      // 5: load ignored in RUN, start+pause, DONE handling
      cyc(1'b1, 0, 3, 1'b0, 1'b0);
      cyc(1'b0, 0, 0, 1'b1, 1'b0);
      cyc(1'b1, 0, 10, 1'b0, 1'b0);
      chk("t5_load_ign_ss",  int'(ss),      3);
      chk("t5_load_ign_run", int'(running), 1);
      cyc(1'b0, 0, 0, 1'b1, 1'b1);
      chk("t5_sp_run_pause", int'(running), 0);
      cyc(1'b0, 0, 0, 1'b1, 1'b1);
      chk("t5_sp_pause_run", int'(running), 1);
      idle(20);
      chk("t5_expired", int'(expired), 1);
      cyc(1'b0, 0, 0, 1'b1, 1'b0);
      chk("t5_done_start_exp", int'(expired), 1);
      chk("t5_done_start_run", int'(running), 0);
      cyc(1'b0, 0, 0, 1'b0, 1'b1);
      cyc(1'b1, 0, 2, 1'b0, 1'b0);
      chk("t5_reload_exp", int'(expired), 0);
      chk("t5_reload_ss",  int'(ss),      2);
      chk("t5_reload_run", int'(running), 0);

      // 6: asynchronous reset in the middle of a count
      cyc(1'b1, 0, 30, 1'b0, 1'b0);
      cyc(1'b0, 0, 0, 1'b1, 1'b0);
      idle(5);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_mm",      int'(mm),      0);
      chk("t6_ss",      int'(ss),      0);
      chk("t6_running", int'(running), 0);
      chk("t6_done",    int'(done),    0);
      chk("t6_expired", int'(expired), 0);
      #1;
      rst = 1'b0;
      @(negedge clk);
      cyc(1'b0, 0, 0, 1'b1, 1'b0);
      chk("t6_idle_after", int'(running), 0);
      idle(3);
      cyc(1'b1, 0, 1, 1'b0, 1'b0);
      cyc(1'b0, 0, 0, 1'b1, 1'b0);
      idle(4);
      chk("t6_post_done", int'(done), 1);
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
